// File: rtl/context_table.sv
// Program context table. It saves each user program's resume address when control passes to the OS.
// On an OS restore request it round-robins to the next unfinished program and issues a one-cycle PC load.
module context_table #(
    parameter int NUM_PROG = 2,
    parameter int ADDR_W   = 32,
    parameter int STRIDE   = 1000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              save_req,
    input  logic [ADDR_W-1:0] save_addr,
    input  logic [2:0]        cur_prog,
    input  logic              end_req,
    input  logic              restore_req,
    output logic              lpc,
    output logic [ADDR_W-1:0] endereco_pc,
    output logic [2:0]        next_prog,
    output logic              busy,
    output logic              all_done,
    output logic              addr_err
);

    typedef enum logic [1:0] {IDLE, SEARCH, ISSUE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   slot [1:NUM_PROG];
    logic [NUM_PROG:1]   done;
    logic [2:0]          last_prog;
    logic [2:0]          cand;
    logic                pending;

    logic                save_ok;
    logic                end_ok;
    logic [3:0]          pick;
    logic [ADDR_W-1:0]   cand_addr;

    function automatic logic id_ok(input logic [2:0] p);
        return (p != 3'd0) && (int'(p) <= NUM_PROG);
    endfunction

    function automatic logic [ADDR_W-1:0] base_of(input logic [2:0] p);
        return ADDR_W'(p) * ADDR_W'(STRIDE);
    endfunction

    function automatic logic below_base(input logic [ADDR_W-1:0] a, input logic [2:0] p);
        return a < base_of(p);
    endfunction

    // Addresses under the program's base clamp to 0 instead of wrapping.
    function automatic logic [ADDR_W-1:0] rel_addr(input logic [ADDR_W-1:0] a, input logic [2:0] p);
        return below_base(a, p) ? '0 : a - base_of(p);
    endfunction

    // Returns {found, id}: first unfinished program after last, wrapping around to last itself.
    function automatic logic [3:0] pick_next(input logic [2:0] last, input logic [NUM_PROG:1] dn);
        logic       found;
        logic [2:0] id;
        int         p;
        found = 1'b0;
        id    = 3'd0;
        for (int i = 1; i <= NUM_PROG; i++) begin
            p = ((int'(last) - 1 + i) % NUM_PROG) + 1;
            if (!found && !dn[p]) begin
                found = 1'b1;
                id    = 3'(p);
            end
        end
        return {found, id};
    endfunction

    assign save_ok = save_req && id_ok(cur_prog);
    assign end_ok  = end_req && id_ok(cur_prog);
    assign pick    = pick_next(last_prog, done);

    always_comb begin
        cand_addr = '0;
        for (int p = 1; p <= NUM_PROG; p++)
            if (cand == 3'(p)) cand_addr = slot[p];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int p = 1; p <= NUM_PROG; p++) slot[p] <= '0;
            done        <= '0;
            last_prog   <= 3'd1;
            cand        <= 3'd0;
            pending     <= 1'b0;
            state       <= IDLE;
            lpc         <= 1'b0;
            endereco_pc <= '0;
            next_prog   <= 3'd0;
            busy        <= 1'b0;
            all_done    <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            lpc      <= 1'b0;
            all_done <= (&done) || (state == SEARCH && !pick[3]);

            case (state)
                IDLE: begin
                    if (restore_req || pending) begin
                        state   <= SEARCH;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                    end
                end
                SEARCH: begin
                    if (restore_req) pending <= 1'b1;
                    if (pick[3]) begin
                        cand  <= pick[2:0];
                        state <= ISSUE;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (restore_req) pending <= 1'b1;
                    lpc         <= 1'b1;
                    endereco_pc <= cand_addr;
                    next_prog   <= cand;
                    last_prog   <= cand;
                    state       <= IDLE;
                    busy        <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // A save lands after the ISSUE update so the most recent running program wins.
            if (save_ok) begin
                last_prog <= cur_prog;
                if (below_base(save_addr, cur_prog)) addr_err <= 1'b1;
            end
            for (int p = 1; p <= NUM_PROG; p++) begin
                if (save_ok && cur_prog == 3'(p)) slot[p] <= rel_addr(save_addr, cur_prog);
                if (end_ok && cur_prog == 3'(p)) done[p] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_context_table.sv
// Directed bench for context_table: a per-cycle vector table plus hand-written
// sequences for a restore queued while busy and for reset arriving during a search.
module tb_context_table;

    localparam int AW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          save_req = 1'b0;
    logic [AW-1:0] save_addr = '0;
    logic [2:0]    cur_prog = 3'd0;
    logic          end_req = 1'b0;
    logic          restore_req = 1'b0;
    logic          lpc;
    logic [AW-1:0] endereco_pc;
    logic [2:0]    next_prog;
    logic          busy;
    logic          all_done;
    logic          addr_err;

    int checks = 0;
    int failures = 0;

    context_table #(.NUM_PROG(2), .ADDR_W(AW), .STRIDE(1000)) dut (
        .clock(clock), .reset(reset),
        .save_req(save_req), .save_addr(save_addr), .cur_prog(cur_prog),
        .end_req(end_req), .restore_req(restore_req),
        .lpc(lpc), .endereco_pc(endereco_pc), .next_prog(next_prog),
        .busy(busy), .all_done(all_done), .addr_err(addr_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          sv;
        logic [AW-1:0] sa;
        logic [2:0]    cp;
        logic          en;
        logic          rs;
        logic          e_lpc;
        logic [AW-1:0] e_ep;
        logic [2:0]    e_np;
        logic          e_busy;
        logic          e_ad;
        logic          e_ae;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(input bit sv, input int sa, input int cp, input bit en, input bit rs,
                                input bit l, input int ep, input int np, input bit bz, input bit ad,
                                input bit ae);
        vec_t v;
        v.sv = sv; v.sa = AW'(sa); v.cp = 3'(cp); v.en = en; v.rs = rs;
        v.e_lpc = l; v.e_ep = AW'(ep); v.e_np = 3'(np); v.e_busy = bz; v.e_ad = ad; v.e_ae = ae;
        return v;
    endfunction

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic l, input logic [AW-1:0] ep, input logic [2:0] np,
                           input logic bz, input logic ad, input logic ae);
        chk({tag, ".lpc"}, AW'(lpc), AW'(l));
        chk({tag, ".endereco_pc"}, endereco_pc, ep);
        chk({tag, ".next_prog"}, AW'(next_prog), AW'(np));
        chk({tag, ".busy"}, AW'(busy), AW'(bz));
        chk({tag, ".all_done"}, AW'(all_done), AW'(ad));
        chk({tag, ".addr_err"}, AW'(addr_err), AW'(ae));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        save_req = 1'b0; save_addr = '0; cur_prog = 3'd0; end_req = 1'b0; restore_req = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        clear_inputs();
        reset = 1'b0;
        step();
        step();
        chk_all(tag, 1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        //          sv sa    cp en rs | lpc ep np bz ad ae
        tbl[0]  = mk(0, 0,    0, 0, 1,  0, 0,  0, 1, 0, 0);
        tbl[1]  = mk(0, 0,    0, 0, 0,  0, 0,  0, 1, 0, 0);
        tbl[2]  = mk(0, 0,    0, 0, 0,  1, 0,  2, 0, 0, 0);
        tbl[3]  = mk(1, 500,  3, 0, 0,  0, 0,  2, 0, 0, 0);
        tbl[4]  = mk(1, 1006, 1, 0, 0,  0, 0,  2, 0, 0, 0);
        tbl[5]  = mk(0, 0,    0, 0, 1,  0, 0,  2, 1, 0, 0);
        tbl[6]  = mk(0, 0,    0, 0, 0,  0, 0,  2, 1, 0, 0);
        tbl[7]  = mk(0, 0,    0, 0, 0,  1, 0,  2, 0, 0, 0);
        tbl[8]  = mk(1, 2004, 2, 0, 1,  0, 0,  2, 1, 0, 0);
        tbl[9]  = mk(0, 0,    0, 0, 0,  0, 0,  2, 1, 0, 0);
        tbl[10] = mk(0, 0,    0, 0, 0,  1, 6,  1, 0, 0, 0);
        tbl[11] = mk(1, 1500, 2, 0, 0,  0, 6,  1, 0, 0, 1);
        tbl[12] = mk(1, 1003, 1, 0, 0,  0, 6,  1, 0, 0, 1);
        tbl[13] = mk(0, 0,    0, 0, 1,  0, 6,  1, 1, 0, 1);
        tbl[14] = mk(0, 0,    0, 0, 0,  0, 6,  1, 1, 0, 1);
        tbl[15] = mk(0, 0,    0, 0, 0,  1, 0,  2, 0, 0, 1);
        tbl[16] = mk(0, 0,    2, 1, 0,  0, 0,  2, 0, 0, 1);
        tbl[17] = mk(1, 1010, 1, 0, 0,  0, 0,  2, 0, 0, 1);
        tbl[18] = mk(0, 0,    0, 0, 1,  0, 0,  2, 1, 0, 1);
        tbl[19] = mk(0, 0,    0, 0, 0,  0, 0,  2, 1, 0, 1);
        tbl[20] = mk(0, 0,    0, 0, 0,  1, 10, 1, 0, 0, 1);
        tbl[21] = mk(0, 0,    1, 1, 0,  0, 10, 1, 0, 0, 1);
        tbl[22] = mk(0, 0,    0, 0, 1,  0, 10, 1, 1, 1, 1);
        tbl[23] = mk(0, 0,    0, 0, 0,  0, 10, 1, 0, 1, 1);
        tbl[24] = mk(0, 0,    0, 0, 0,  0, 10, 1, 0, 1, 1);

        do_reset("reset0");
        for (int i = 0; i < 25; i++) begin
            save_req = tbl[i].sv; save_addr = tbl[i].sa; cur_prog = tbl[i].cp;
            end_req = tbl[i].en; restore_req = tbl[i].rs;
            step();
            clear_inputs();
            chk_all($sformatf("row%0d", i), tbl[i].e_lpc, tbl[i].e_ep, tbl[i].e_np,
                    tbl[i].e_busy, tbl[i].e_ad, tbl[i].e_ae);
        end

        // Restore arriving during SEARCH is queued and serviced after the first ISSUE.
        do_reset("reset1");
        restore_req = 1'b1;
        step();
        chk_all("pend.e0", 1'b0, '0, 3'd0, 1'b1, 1'b0, 1'b0);
        step();
        restore_req = 1'b0;
        chk_all("pend.e1", 1'b0, '0, 3'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("pend.e2", 1'b1, '0, 3'd2, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("pend.e3", 1'b0, '0, 3'd2, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("pend.e4", 1'b0, '0, 3'd2, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("pend.e5", 1'b1, '0, 3'd1, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("pend.e6", 1'b0, '0, 3'd1, 1'b0, 1'b0, 1'b0);

        // Reset during SEARCH clears outputs at once and no load follows.
        do_reset("reset2");
        save_req = 1'b1; save_addr = AW'(2500); cur_prog = 3'd2;
        step();
        clear_inputs();
        restore_req = 1'b1;
        step();
        restore_req = 1'b0;
        chk_all("abort.search", 1'b0, '0, 3'd0, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1 chk_all("abort.async", 1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all($sformatf("abort.after%0d", i), 1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/context_table.md
Name: context_table

Overview:
- Upstream neighbour of the program counter. Saves each user program's resume address when the PC hands control to the OS (address 0).
- On an OS restore request it picks the next runnable program round-robin. It then drives a one-cycle load pulse with that program's relative resume address into the PC's load inputs (lpc / enderecoPc).
- It also tracks finished programs and flags when all are done.

Parameters:
- NUM_PROG, 2, number of user programs; ids 1..NUM_PROG (id 0 = OS)
- ADDR_W, 32, address width
- STRIDE, 1000, absolute base of program p is p*STRIDE

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- save_req  in  1  pulse: PC just switched to the OS; capture save_addr
- save_addr  in  ADDR_W  absolute resume address from the PC (enderecoSpc)
- cur_prog  in  3  id of the program that was running at save_req/end_req
- end_req  in  1  pulse: program cur_prog executed its end instruction
- restore_req  in  1  pulse from the OS: resume the next program
- lpc  out  1  one-cycle load strobe to the PC
- endereco_pc  out  ADDR_W  relative resume address for the PC (PC adds the offset)
- next_prog  out  3  id of the program being resumed; valid while lpc=1
- busy  out  1  FSM not in IDLE
- all_done  out  1  every program finished
- addr_err  out  1  sticky: save_addr was below its program's base

Behaviour:
- Reset (async, reset=0): slot[p]=0 and done[p]=0 for all p; last_prog=1; state=IDLE.
- Reset also clears every output to 0: lpc, endereco_pc, next_prog, busy, all_done, addr_err. No pending flag survives reset.
- Reset asserted mid-operation aborts any SEARCH/ISSUE immediately. No lpc pulse is issued afterwards.
- FSM states are IDLE, SEARCH, ISSUE; all transitions occur on the rising clock edge.
- Save:
  - In any state, save_req with cur_prog in 1..NUM_PROG writes slot[cur_prog] = save_addr - cur_prog*STRIDE, truncated to ADDR_W. It also sets last_prog=cur_prog.
  - If save_addr < cur_prog*STRIDE: slot gets 0 and addr_err is set; addr_err stays set until reset.
  - save_req with cur_prog=0 or cur_prog>NUM_PROG is ignored.
- End: end_req sets done[cur_prog]=1, with the same id check as save. end_req and save_req in the same cycle both take effect.
- Restore:
  - restore_req in IDLE goes to SEARCH. restore_req arriving while busy is latched as pending and serviced on return to IDLE (at most one pending).
  - A save_req in the same cycle as restore_req is applied first, so the search sees the updated last_prog.
- SEARCH (exactly 1 cycle):
  - Candidate = first p with done[p]=0, scanning last_prog+1 .. NUM_PROG, then wrapping 1 .. last_prog.
  - If NUM_PROG=1 or only one program is undone, that program is selected, including last_prog itself.
  - If a candidate exists: go to ISSUE. Otherwise set all_done=1 and return to IDLE with no lpc.
- ISSUE (exactly 1 cycle):
  - lpc=1, endereco_pc=slot[candidate], next_prog=candidate; last_prog=candidate; then return to IDLE.
  - Latency from restore_req to lpc is 2 cycles: request sampled at edge N, lpc high during cycle N+2.
- endereco_pc and next_prog hold their last values after lpc drops.
- all_done is combinationally equal to AND of all done[p], registered. It stays 1 until reset.

Test Plan:
- Reset then restore_req → lpc pulses 2 cycles later with next_prog=2 (round-robin after last_prog=1) and endereco_pc=0; busy high for 2 cycles.
- save_req, cur_prog=1, save_addr=1006 → slot1=6. Then restore_req → next_prog=2, endereco_pc=0. Then save(2, 2004) and restore → next_prog=1, endereco_pc=6.
- end_req cur_prog=2, then save(1, 1010) and restore → next_prog=1, endereco_pc=10 (program 2 skipped).
- end_req for programs 1 and 2, then restore_req → no lpc pulse and all_done=1 within 2 cycles.
- save(2, 1500) → addr_err=1 and slot2=0; a following restore selecting program 2 drives endereco_pc=0.
- restore_req while in SEARCH → second lpc pulse exactly 2 cycles after the first ISSUE returns to IDLE. reset=0 asserted during SEARCH → no lpc, all outputs 0.
